// File: rtl/mips_loader_if.sv
// rtl/mips_loader_if.sv - byte-stream input and instruction-memory write port bundle
interface mips_loader_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  imem_w_addr;
  logic [31:0] imem_w_data;
  logic        imem_w_en;

  // host side: drives the byte stream, observes the memory write port
  modport master (
    output s_data, s_valid,
    input  s_ready, imem_w_addr, imem_w_data, imem_w_en
  );

  // loader side
  modport slave (
    input  s_data, s_valid,
    output s_ready, imem_w_addr, imem_w_data, imem_w_en
  );
endinterface

// File: rtl/mips_loader.sv
// rtl/mips_loader.sv - boot/run controller for the 8-bit MIPS core (optional MIPS_LOADER_CHECKSUM_EN)
module mips_loader #(
  parameter logic [15:0] RUN_CYCLES = 16'd1000,
  parameter int          MAX_WORDS  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  mips_loader_if.slave bus,
  output logic         cpu_rst,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [15:0]  run_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_CSUM, S_ARM, S_RUN, S_DONE, S_ERROR
  } state_t;

  localparam logic [7:0] MAX_WORDS_B = 8'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] asm_q, asm_d;
  logic [7:0]  imem_w_addr_q, imem_w_addr_d;
  logic [31:0] imem_w_data_q, imem_w_data_d;
  logic        imem_w_en_q, imem_w_en_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic        s_ready_q, s_ready_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        take;
`ifdef MIPS_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  sum_chk;
`endif

  assign take = bus.s_valid && s_ready_q;
`ifdef MIPS_LOADER_CHECKSUM_EN
  assign sum_chk = sum_q + bus.s_data;
`endif

  // next-state and next-output computation; outputs are derived from state_d so they register cleanly
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    word_idx_d    = word_idx_q;
    byte_idx_d    = byte_idx_q;
    asm_d         = asm_q;
    imem_w_addr_d = imem_w_addr_q;
    imem_w_data_d = imem_w_data_q;
    imem_w_en_d   = 1'b0;
    run_cnt_d     = run_cnt_q;
`ifdef MIPS_LOADER_CHECKSUM_EN
    sum_d         = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HDR;
      end
      S_HDR: begin
        if (stop) begin
          state_d = S_ERROR;
        end else if (take) begin
          if (bus.s_data == 8'd0 || bus.s_data > MAX_WORDS_B) begin
            state_d = S_ERROR;
          end else begin
            word_cnt_d = bus.s_data;
            word_idx_d = 8'd0;
            byte_idx_d = 2'd0;
            state_d    = S_LOAD;
          end
`ifdef MIPS_LOADER_CHECKSUM_EN
          sum_d = bus.s_data;
`endif
        end
      end
      S_LOAD: begin
        // stop wins over a coinciding 4th byte so a partial/aborted word is never written
        if (stop) begin
          state_d = S_ERROR;
        end else if (take) begin
          asm_d      = {asm_q[15:0], bus.s_data};
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef MIPS_LOADER_CHECKSUM_EN
          sum_d      = sum_chk;
`endif
          if (byte_idx_q == 2'd3) begin
            imem_w_data_d = {asm_q, bus.s_data};
            imem_w_addr_d = {word_idx_q[5:0], 2'b00};
            imem_w_en_d   = 1'b1;
            word_idx_d    = word_idx_q + 8'd1;
            if (word_idx_q == word_cnt_q - 8'd1) begin
`ifdef MIPS_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_ARM;
`endif
            end
          end
        end
      end
`ifdef MIPS_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (stop) begin
          state_d = S_ERROR;
        end else if (take) begin
          state_d = (sum_chk == 8'h00) ? S_ARM : S_ERROR;
        end
      end
`endif
      S_ARM: begin
        state_d   = S_RUN;
        run_cnt_d = 16'd0;
      end
      S_RUN: begin
        // the exit cycle does not count up, so run_cnt ends at the last cycle index
        if (stop || (RUN_CYCLES != 16'd0 && run_cnt_q == RUN_CYCLES - 16'd1)) begin
          state_d = S_DONE;
        end else if (run_cnt_q != 16'hFFFF) begin
          run_cnt_d = run_cnt_q + 16'd1;
        end
      end
      S_DONE, S_ERROR: begin
        if (start) state_d = S_HDR;
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CSUM);
    cpu_rst_d = (state_d != S_RUN);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERROR);
  end

  // state and registered outputs; reset parks the core in reset with no write in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      word_cnt_q    <= 8'd0;
      word_idx_q    <= 8'd0;
      byte_idx_q    <= 2'd0;
      asm_q         <= 24'd0;
      imem_w_addr_q <= 8'd0;
      imem_w_data_q <= 32'd0;
      imem_w_en_q   <= 1'b0;
      run_cnt_q     <= 16'd0;
      s_ready_q     <= 1'b0;
      cpu_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
      sum_q         <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      word_idx_q    <= word_idx_d;
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      imem_w_addr_q <= imem_w_addr_d;
      imem_w_data_q <= imem_w_data_d;
      imem_w_en_q   <= imem_w_en_d;
      run_cnt_q     <= run_cnt_d;
      s_ready_q     <= s_ready_d;
      cpu_rst_q     <= cpu_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
`ifdef MIPS_LOADER_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.imem_w_addr = imem_w_addr_q;
  assign bus.imem_w_data = imem_w_data_q;
  assign bus.imem_w_en   = imem_w_en_q;
  assign cpu_rst         = cpu_rst_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign run_cnt         = run_cnt_q;

endmodule

// File: tb/tb_mips_loader.sv
// tb/tb_mips_loader.sv - self-checking bench for mips_loader
`timescale 1ns/1ps
module tb_mips_loader;
  localparam logic [15:0] RUN_CYCLES = 16'd1000;
  localparam int          MAX_WORDS  = 64;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  // inputs: header, word source (0 random, 1 fixed pair, 2 zeros), max idle gap,
  // stream index to stop at, run_cnt to stop at, checksum corruption; expected: done, error
  typedef struct {
    logic [7:0] hdr;
    int         word_mode;
    int         max_gap;
    int         stop_at;
    int         stop_run_at;
    logic [7:0] csum_xor;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cpu_rst, busy, done, error;
  logic [15:0] run_cnt;

  int   n_checks = 0;
  int   n_fail = 0;
  wr_t  got_q[$];
  int   run_seen = 0;
  vec_t vecs[$];

  mips_loader_if bus();

  mips_loader #(.RUN_CYCLES(RUN_CYCLES), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;

  // observe write strobes and unreset core cycles
  always @(negedge clk) begin
    if (bus.imem_w_en === 1'b1) got_q.push_back({bus.imem_w_addr, bus.imem_w_data});
    if (cpu_rst === 1'b0) run_seen++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_hdr", 64'({busy, bus.s_ready, done, error, cpu_rst}), 64'(5'b11001));
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_load(input vec_t v);
    logic [31:0] words[$];
    logic [7:0]  stream[$];
    wr_t         exp_q[$];
    logic [31:0] w;
    logic [7:0]  sum;
    bit          hdr_ok;
    bit          ok;
    int          n_send;
    int          exp_run;
    int          exp_cnt;

    // reference: build the byte stream and derive the writes the loader must issue
    hdr_ok = (v.hdr != 8'd0) && (int'(v.hdr) <= MAX_WORDS);
    stream.push_back(v.hdr);
    if (hdr_ok) begin
      for (int i = 0; i < int'(v.hdr); i++) begin
        case (v.word_mode)
          1:       w = (i == 0) ? 32'h20010005 : 32'h08000001;
          2:       w = 32'h0;
          default: w = $urandom;
        endcase
        words.push_back(w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
      end
`ifdef MIPS_LOADER_CHECKSUM_EN
      sum = 8'd0;
      foreach (stream[j]) sum = sum + stream[j];
      stream.push_back((8'h00 - sum) ^ v.csum_xor);
`endif
    end
    n_send = (v.stop_at >= 0) ? v.stop_at : stream.size();
    foreach (words[i]) if (4 * i + 4 < n_send) exp_q.push_back({8'(4 * i), words[i]});
    exp_run = !v.exp_done ? 0 : (v.stop_run_at >= 0 ? v.stop_run_at + 1 : int'(RUN_CYCLES));
    exp_cnt = (v.stop_run_at >= 0) ? v.stop_run_at : int'(RUN_CYCLES) - 1;

    got_q.delete();
    run_seen = 0;
    do_start();
    for (int i = 0; i < n_send; i++) send_byte(stream[i], v.max_gap);
    if (v.stop_at >= 0) begin
      bus.s_valid = 1'b1;
      bus.s_data  = stream[v.stop_at];
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      bus.s_valid = 1'b0;
    end else begin
      bus.s_data = 8'hA5;
    end

    if (v.exp_done) begin
      @(negedge clk);
      check("arm_cycle", 64'({cpu_rst, busy, done}), 64'(3'b110));
`ifndef MIPS_LOADER_CHECKSUM_EN
      check("arm_last_strobe", 64'(bus.imem_w_en), 64'd1);
`endif
      @(negedge clk);
      check("run_entry", 64'({cpu_rst, run_cnt}), 64'd0);
    end else begin
      @(negedge clk);
    end

    ok = 1'b0;
    for (int t = 0; t < int'(RUN_CYCLES) + 200; t++) begin
      if (done || error) begin
        ok = 1'b1;
        break;
      end
      if (v.stop_run_at >= 0 && !cpu_rst && int'(run_cnt) == v.stop_run_at) begin
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    check("end_reached", 64'(ok), 64'd1);
    check("end_flags", 64'({done, error, cpu_rst, busy}), 64'({v.exp_done, v.exp_err, 1'b1, 1'b0}));
    check("wr_count", 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) if (i < got_q.size()) check("wr_entry", 64'(got_q[i]), 64'(exp_q[i]));
    check("run_cycles", 64'(run_seen), 64'(exp_run));
    if (v.exp_done) begin
      repeat (3) @(negedge clk);
      check("done_hold", 64'({done, run_cnt}), 64'({1'b1, 16'(exp_cnt)}));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit reached;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'd0;
    #1 rst = 1'b0;
    #1;
    check("reset_outs", 64'({cpu_rst, busy, done, error, bus.s_ready, bus.imem_w_en}), 64'(6'b100000));
    check("reset_bus", 64'({bus.imem_w_addr, bus.imem_w_data, run_cnt}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{8'h02, 1, 0, -1, -1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h03, 0, 3, -1, -1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h00, 0, 0, -1, -1, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'h41, 0, 0, -1, -1, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'hFF, 0, 0, -1, -1, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'h01, 0, 0, -1, -1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h40, 0, 1, -1, -1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h03, 0, 0,  6, -1, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'h02, 0, 0, -1, 10, 8'h00, 1'b1, 1'b0});
`ifdef MIPS_LOADER_CHECKSUM_EN
    vecs.push_back('{8'h01, 2, 0, -1, -1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h01, 2, 0, -1, -1, 8'hFF, 1'b0, 1'b1});
`endif
    foreach (vecs[i]) run_load(vecs[i]);

    for (int r = 0; r < 5; r++) begin
      vec_t v;
      v.hdr         = (r == 4) ? 8'($urandom_range(255, 65)) : 8'($urandom_range(8, 1));
      v.word_mode   = 0;
      v.max_gap     = 2;
      v.stop_at     = -1;
      v.stop_run_at = -1;
      v.csum_xor    = 8'h00;
      v.exp_done    = (v.hdr != 8'd0) && (int'(v.hdr) <= MAX_WORDS);
      v.exp_err     = !v.exp_done;
      run_load(v);
    end

    // asynchronous reset while the first word's strobe is visible
    do_start();
    send_byte(8'h03, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    #3 rst = 1'b0;
    #1;
    check("rst_load_outs", 64'({cpu_rst, busy, done, error, bus.s_ready, bus.imem_w_en}), 64'(6'b100000));
    check("rst_load_bus", 64'({bus.imem_w_addr, bus.imem_w_data, run_cnt}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    got_q.delete();
    repeat (8) @(negedge clk);
    check("rst_load_quiet", 64'({got_q.size() == 0, cpu_rst, busy, bus.s_ready}), 64'(4'b1100));
    @(posedge clk); #1;
    bus.s_valid = 1'b0;

    // asynchronous reset during the run
    do_start();
    send_byte(8'h01, 0);
    repeat (4) send_byte(8'h00, 0);
`ifdef MIPS_LOADER_CHECKSUM_EN
    send_byte(8'hFF, 0);
`endif
    bus.s_valid = 1'b0;
    reached = 1'b0;
    for (int t = 0; t < 100 && !reached; t++) begin
      @(negedge clk);
      reached = (cpu_rst == 1'b0) && (run_cnt == 16'd20);
    end
    check("rst_run_reached", 64'(reached), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_run_outs", 64'({cpu_rst, busy, done, error, run_cnt}), 64'({4'b1000, 16'd0}));
    @(posedge clk); #1;
    rst = 1'b1;
    got_q.delete();
    run_seen = 0;
    repeat (6) @(negedge clk);
    check("rst_run_quiet", 64'({got_q.size() == 0, run_seen == 0, cpu_rst, busy}), 64'(4'b1110));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_loader.md
Name: mips_loader

Overview:
- Boot and run controller for the 8-bit 5-stage MIPS core.
- Accepts a byte-stream program image over a valid/ready port and assembles bytes into 32-bit instruction words.
- Writes the words into instruction memory while holding the core in reset, then releases the core for a bounded run.
- Reports done or error to the host. Sits between the host/test interface, the instruction memory write port and the core's reset input.

Parameters:
- RUN_CYCLES, 16'd1000, core-active cycles per run; 0 = unlimited (only stop ends the run).
- MAX_WORDS, 64, largest legal word count; the core's 8-bit byte address space holds 64 words.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a load; level-sampled
- stop  in  1  end run / abort load
- s_data  in  8  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  loader accepts byte
- imem_w_addr  out  8  instruction-memory byte address (word-aligned)
- imem_w_data  out  32  instruction word
- imem_w_en  out  1  instruction-memory write strobe
- cpu_rst  out  1  active-high reset to the core
- busy  out  1  state is not IDLE/DONE/ERROR
- done  out  1  run completed
- error  out  1  load failed
- run_cnt  out  16  cycles the core has run in this run

Behaviour:
- Reset (rst=0, async): state=IDLE, cpu_rst=1, s_ready=0, imem_w_en=0, imem_w_addr=0, imem_w_data=0, done=0, error=0, busy=0, run_cnt=0. Reset mid-load or mid-run aborts immediately; no partial write strobe is issued.
- Byte handshake: a byte transfers in a cycle with s_valid && s_ready. s_ready is 1 only in HDR, LOAD and CSUM.
- IDLE: start=1 -> HDR.
- HDR: first byte = word count N.
  - N==0 or N>MAX_WORDS -> ERROR.
  - Otherwise word_idx=0, byte_idx=0 -> LOAD.
- LOAD: bytes arrive MSB first and shift into a 32-bit assembly register.
  - On the 4th byte: imem_w_data=assembled word, imem_w_addr={word_idx[5:0],2'b00}, imem_w_en=1 for exactly the next cycle. word_idx increments and byte_idx wraps to 0.
  - Back-to-back words are legal; a strobe can occur every 4th cycle.
  - After word N-1 -> ARM (or CSUM when the checksum feature is enabled).
- ARM: one cycle; the final write strobe is visible here, cpu_rst still 1 -> RUN.
- RUN: cpu_rst=0.
  - run_cnt clears to 0 on entry and increments every RUN cycle, saturating at 16'hFFFF.
  - With RUN_CYCLES!=0, when run_cnt==RUN_CYCLES-1 the next state is DONE, so the core sees exactly RUN_CYCLES unreset cycles.
  - stop=1 -> DONE next cycle. stop and limit in the same cycle -> DONE.
- DONE: cpu_rst=1, done=1, run_cnt holds its final value. start -> HDR, and done clears.
- ERROR: cpu_rst=1, error=1. start -> HDR, and error clears.
- stop in HDR/LOAD/CSUM -> ERROR; any partly assembled word is discarded.
- start is ignored in HDR, LOAD, CSUM, ARM and RUN.
- cpu_rst is registered and glitch-free. It is 1 in every state except RUN.
- busy=1 in HDR, LOAD, CSUM, ARM and RUN.
- imem_w_addr and imem_w_data hold their last values between strobes.

Optional Feature:
- Macro: MIPS_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) covers the count byte and all payload bytes.
  - After the last payload byte the state is CSUM, which accepts one more byte.
  - If sum + byte == 8'h00, go to ARM; otherwise go to ERROR and the core is never released.
  - Words already written stay written.
- Undefined: no CSUM state; LOAD goes directly to ARM and no trailing byte is consumed.

Test Plan:
1. Stream N=2, words 0x20010005, 0x08000001 with s_valid held high. Expect strobes at addr 0x00 and 0x04 with the exact data, then one ARM cycle with cpu_rst=1, then cpu_rst=0 for exactly RUN_CYCLES cycles, then done=1 and run_cnt=RUN_CYCLES-1.
2. s_valid toggled randomly during a 3-word load. Expect only handshaked bytes consumed, word order and addresses 0x00/0x04/0x08 correct, and exactly one strobe per word.
3. Header 0x00, and separately header 0x41 (MAX_WORDS=64). Expect ERROR, error=1, cpu_rst=1, no imem_w_en; then start -> HDR with error cleared.
4. stop during RUN at run_cnt=10, and separately at the 2nd byte of word 1. Expect DONE with run_cnt=10 in the first case; ERROR with no strobe for word 1 in the second.
5. rst pulsed low mid-LOAD and mid-RUN. Expect all outputs at their reset values immediately (asynchronous), cpu_rst=1, and no spurious strobe after rst releases.
6. (MIPS_LOADER_CHECKSUM_EN) N=1, word 0x00000000, checksum byte 0xFF. Expect RUN. Same stream with checksum 0x00: expect ERROR, cpu_rst stays 1.
